// File: rtl/mul_wb_hazard_ctrl.sv
// Multiply issue-to-writeback sequencer, register-file write-port arbiter with the ALU, and decode hazard stalls.
// Latency: an uncontended Mul_Start at cycle t writes back at t+MUL_LATENCY; the ALU wins the port for up to MAX_DEFER cycles.
// Backpressure: Stall_D holds decode on RAW/structural hazards and Alu_Hold holds the ALU; MUL_KILL_EN adds the Mul_Kill squash.
module mul_wb_hazard_ctrl #(
  parameter int DATA_WIDTH  = 5,
  parameter int MUL_LATENCY = 4,
  parameter int MAX_DEFER   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Mul_Start,
  input  logic [DATA_WIDTH-1:0] Mul_Rd,
  input  logic [DATA_WIDTH-1:0] D_Rs1,
  input  logic [DATA_WIDTH-1:0] D_Rs2,
  input  logic                  D_UseRs1,
  input  logic                  D_UseRs2,
  input  logic                  D_IsMul,
  input  logic                  WB_Alu_Req,
`ifdef MUL_KILL_EN
  input  logic                  Mul_Kill,
`endif
  output logic                  Stall_D,
  output logic                  Alu_Hold,
  output logic                  Mul_Busy,
  output logic                  W_RegMul,
  output logic [DATA_WIDTH-1:0] W_Rd_Mul
);

  localparam int CNT_W = $clog2(MUL_LATENCY);
  localparam int DEF_W = $clog2(MAX_DEFER + 1);

  typedef enum logic [1:0] {IDLE, BUSY, WB} state_t;

  state_t                state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [DEF_W-1:0]      defer, defer_nxt;
  logic [DATA_WIDTH-1:0] rd, rd_nxt;
  logic                  grant, defer_max, kill, rd_hit, raw_stall, str_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      defer <= '0;
      rd    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      defer <= defer_nxt;
      rd    <= rd_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    defer_nxt = defer;
    rd_nxt    = rd;
    grant     = 1'b0;
    defer_max = (defer == DEF_W'(MAX_DEFER));
`ifdef MUL_KILL_EN
    kill      = Mul_Kill && (state != IDLE);
`else
    kill      = 1'b0;
`endif

    case (state)
      IDLE: begin
        if (Mul_Start) begin
          rd_nxt    = Mul_Rd;
          cnt_nxt   = CNT_W'(MUL_LATENCY - 1);
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        // Leave BUSY as the count reaches zero so writeback lands exactly MUL_LATENCY cycles after issue.
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        if (cnt <= CNT_W'(1)) state_nxt = WB;
      end
      WB: begin
        grant = !WB_Alu_Req || defer_max;
        if (grant) begin
          defer_nxt = '0;
          if (Mul_Start) begin
            rd_nxt    = Mul_Rd;
            cnt_nxt   = CNT_W'(MUL_LATENCY - 1);
            state_nxt = BUSY;
          end else begin
            state_nxt = IDLE;
          end
        end else if (!defer_max) begin
          defer_nxt = defer + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // A squash beats both the writeback grant and a back-to-back issue.
    if (kill) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      defer_nxt = '0;
      grant     = 1'b0;
    end
  end

  always_comb begin
    rd_hit    = (rd != '0) &&
                ((D_UseRs1 && (D_Rs1 == rd)) || (D_UseRs2 && (D_Rs2 == rd)));
    raw_stall = ((state == BUSY) || ((state == WB) && !grant)) && rd_hit;
    str_stall = D_IsMul && (state != IDLE) && !((state == WB) && grant);
    Stall_D   = !kill && (raw_stall || str_stall);
    Alu_Hold  = !kill && (state == WB) && WB_Alu_Req && defer_max;
    Mul_Busy  = (state != IDLE);
    W_RegMul  = grant && (rd != '0);
    W_Rd_Mul  = W_RegMul ? rd : '0;
  end

endmodule

// File: tb/tb_mul_wb_hazard_ctrl.sv
// Directed bench for mul_wb_hazard_ctrl: per-cycle vector table plus reset and squash sequences.
module tb_mul_wb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       Mul_Start;
  logic [4:0] Mul_Rd, D_Rs1, D_Rs2;
  logic       D_UseRs1, D_UseRs2, D_IsMul, WB_Alu_Req;
  logic       Stall_D, Alu_Hold, Mul_Busy, W_RegMul;
  logic [4:0] W_Rd_Mul;
`ifdef MUL_KILL_EN
  logic       Mul_Kill;
`endif

  int checks = 0;
  int errors = 0;

  mul_wb_hazard_ctrl #(.DATA_WIDTH(5), .MUL_LATENCY(4), .MAX_DEFER(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Mul_Start (Mul_Start),
    .Mul_Rd    (Mul_Rd),
    .D_Rs1     (D_Rs1),
    .D_Rs2     (D_Rs2),
    .D_UseRs1  (D_UseRs1),
    .D_UseRs2  (D_UseRs2),
    .D_IsMul   (D_IsMul),
    .WB_Alu_Req(WB_Alu_Req),
`ifdef MUL_KILL_EN
    .Mul_Kill  (Mul_Kill),
`endif
    .Stall_D   (Stall_D),
    .Alu_Hold  (Alu_Hold),
    .Mul_Busy  (Mul_Busy),
    .W_RegMul  (W_RegMul),
    .W_Rd_Mul  (W_Rd_Mul)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [4:0] rd, rs1, rs2;
    logic       use1, use2, ismul, alu;
    logic       e_stall, e_hold, e_busy, e_wreg;
    logic [4:0] e_wrd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic start, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic use1, input logic use2,
                     input logic ismul, input logic alu, input logic e_stall,
                     input logic e_hold, input logic e_busy, input logic e_wreg,
                     input logic [4:0] e_wrd);
    vec_t v;
    v.start = start; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.use1 = use1; v.use2 = use2; v.ismul = ismul; v.alu = alu;
    v.e_stall = e_stall; v.e_hold = e_hold; v.e_busy = e_busy;
    v.e_wreg = e_wreg; v.e_wrd = e_wrd;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic start, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic use1, input logic use2,
                       input logic ismul, input logic alu);
    Mul_Start = start; Mul_Rd = rd; D_Rs1 = rs1; D_Rs2 = rs2;
    D_UseRs1 = use1; D_UseRs2 = use2; D_IsMul = ismul; WB_Alu_Req = alu;
  endtask

  task automatic chk_all(input string tag, input int idx, input logic st, input logic ho,
                         input logic bu, input logic wr, input logic [4:0] wd);
    chk({tag, " stall"}, idx, 8'(Stall_D), 8'(st));
    chk({tag, " hold"},  idx, 8'(Alu_Hold), 8'(ho));
    chk({tag, " busy"},  idx, 8'(Mul_Busy), 8'(bu));
    chk({tag, " wreg"},  idx, 8'(W_RegMul), 8'(wr));
    chk({tag, " wrd"},   idx, 8'(W_Rd_Mul), 8'(wd));
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef MUL_KILL_EN
    Mul_Kill = 1'b0;
`endif

    // Post-reset idle state.
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    // Latency and RAW on rd=7; an issue while BUSY is ignored.
    add(1, 7, 0, 7, 0, 1, 0, 0,   0, 0, 0, 0, 0);
    add(0, 0, 0, 7, 0, 1, 0, 0,   1, 0, 1, 0, 0);
    add(1, 9, 0, 7, 0, 1, 0, 0,   1, 0, 1, 0, 0);
    add(0, 0, 7, 0, 1, 0, 0, 0,   1, 0, 1, 0, 0);
    add(0, 0, 0, 7, 0, 1, 0, 0,   0, 0, 1, 1, 7);
    add(0, 0, 0, 7, 0, 1, 0, 0,   0, 0, 0, 0, 0);
    // ALU holds the port for two cycles, then the multiply overrides it.
    add(1, 3, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
    add(0, 0, 3, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0);
    add(0, 0, 3, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0);
    add(0, 0, 3, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0);
    add(0, 0, 3, 0, 1, 0, 0, 1,   1, 0, 1, 0, 0);
    add(0, 0, 3, 0, 1, 0, 0, 1,   1, 0, 1, 0, 0);
    add(0, 0, 3, 0, 1, 0, 0, 1,   0, 1, 1, 1, 3);
    add(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
    // Structural stall, back-to-back issue of an x0 multiply.
    add(1, 12, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 1, 0, 0);
    add(0, 0, 12, 0, 1, 0, 0, 0,  1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0);
    add(1, 0, 0, 0, 0, 0, 1, 0,   0, 0, 1, 1, 12);
    add(0, 0, 0, 0, 1, 1, 0, 0,   0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0,   1, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    // Defer count must clear after a grant.
    add(1, 5, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 5);
    add(1, 6, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 1, 6);
    add(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      if (i != 0) begin
        @(posedge clk);
        #1;
      end
      drive(vecs[i].start, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
            vecs[i].use1, vecs[i].use2, vecs[i].ismul, vecs[i].alu);
      @(negedge clk);
      chk_all("vec", i, vecs[i].e_stall, vecs[i].e_hold, vecs[i].e_busy,
              vecs[i].e_wreg, vecs[i].e_wrd);
    end

    // Reset two cycles after issue drops the multiply with no writeback.
    @(posedge clk); #1 drive(1, 5, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("rst issue busy", 0, 8'(Mul_Busy), 8'd0);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); chk("rst inflight busy", 0, 8'(Mul_Busy), 8'd1);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    drive(0, 0, 5, 0, 1, 0, 1, 1);
    @(negedge clk); chk_all("rst after", 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst no wreg", k, 8'(W_RegMul), 8'd0);
      chk("rst no stall", k, 8'(Stall_D), 8'd0);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);

`ifdef MUL_KILL_EN
    // Squash in BUSY overrides hazards and a same-cycle issue.
    @(posedge clk); #1 drive(1, 9, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 drive(1, 4, 9, 0, 1, 0, 1, 0); Mul_Kill = 1'b1;
    @(negedge clk); chk_all("kill busy", 0, 0, 0, 1, 0, 0);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 0); Mul_Kill = 1'b0;
    @(negedge clk); chk("kill idle busy", 0, 8'(Mul_Busy), 8'd0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk); chk("kill no wreg", k, 8'(W_RegMul), 8'd0);
    end
    // Squash in the WB cycle beats the grant.
    @(posedge clk); #1 drive(1, 10, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1 Mul_Kill = 1'b1; WB_Alu_Req = 1'b1;
    @(negedge clk); chk_all("kill wb", 0, 0, 0, 1, 0, 0);
    @(posedge clk); #1 Mul_Kill = 1'b0; WB_Alu_Req = 1'b0;
    @(negedge clk); chk_all("kill wb after", 0, 0, 0, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
